serial_sub32: RTL and testbench
===============================

// Module: serial_sub32
// PURPOSE
//  Multi-cycle chunked subtractor: D = A - B - BIN, computed CHUNK bits per cycle, LSB chunk first.
//  Complements the cond_sum32 adder in the adders library (inverse operation).
//  Serves area-constrained datapaths that can tolerate multi-cycle latency.
//  Exposes a valid/ready handshake on both input and output, and returns borrow/zero/overflow flags.
// PARAMETERS
//  WIDTH   32  operand and result width; must be a multiple of CHUNK
//  CHUNK   8   bits subtracted per cycle; NCHUNK = WIDTH/CHUNK (default 4)
// PORTS
//  clk        in   1      clock; one clock domain
//  rst_n      in   1      reset, synchronous, active-low
//  in_valid   in   1      operands A/B/BIN valid
//  in_ready   out  1      block can accept an operation
//  A          in   WIDTH  minuend, unsigned or two's complement
//  B          in   WIDTH  subtrahend
//  BIN        in   1      borrow in
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts the result
//  D          out  WIDTH  difference, (A - B - BIN) mod 2^WIDTH
//  BOUT       out  1      borrow out: 1 iff unsigned A < B + BIN
//  Z          out  1      D == 0
//  V          out  1      signed overflow: A[MSB] != B[MSB] && D[MSB] != A[MSB]
// BEHAVIOUR
//  Reset: one clock domain (clk). Reset is synchronous and active-low (rst_n sampled on posedge clk).
//   - rst_n=0 at a posedge: state->IDLE; in_ready=1; out_valid=0; D/BOUT/Z/V=0; chunk counter=0.
//   - Reset wins over every other event. An operation in flight when rst_n falls is discarded.
//  FSM states: IDLE, BUSY, DONE.
//   - IDLE: in_ready=1. On in_valid at posedge: latch A, B, BIN; borrow register = BIN; cnt = 0; go to BUSY.
//   - BUSY: in_ready=0. Each cycle, sub_chunk computes one chunk:
//       D[cnt*CHUNK +: CHUNK] = A_chunk - B_chunk - borrow
//       borrow <= chunk borrow-out; cnt++.
//     When cnt == NCHUNK-1 completes: BOUT = final borrow; compute Z and V from the full D; go to DONE.
//   - DONE: out_valid=1, in_ready=0; D/BOUT/Z/V held stable.
//     On out_ready at posedge: out_valid->0 and go to IDLE.
//  Latency and throughput:
//   - Accept at edge T; the last chunk is written at edge T+NCHUNK; out_valid is high during cycle T+NCHUNK (4 for defaults).
//   - Max throughput is one op per NCHUNK+2 cycles; no overlap. in_ready is registered, not combinational.
//  Boundary conditions:
//   - in_valid while not IDLE: ignored; the upstream must hold it.
//   - out_ready while not DONE: ignored.
//   - out_ready already high on entry to DONE: result leaves after exactly one out_valid cycle.
//  Width: chunk math is CHUNK+1 bits ({1'b0,a} - {1'b0,b} - bin); bit CHUNK is the borrow.
//   Wrap-around is modulo 2^WIDTH.
//  Operand registers are not changed by input activity after acceptance.
// STRUCTURE
//  Package adders_pkg:
//   - typedef enum logic [1:0] {SUB_IDLE, SUB_BUSY, SUB_DONE} sub_state_t;
//   - localparam defaults SUB_WIDTH=32, SUB_CHUNK=8.
//  One sub-module, sub_chunk #(CHUNK): combinational, inputs a, b, bin; outputs d, bout.
//  Instantiated once and reused each cycle via a cnt-indexed part-select.
//  Top level holds the FSM, counter, operand/result registers and flag logic.
//  A bind-able property module checks {BOUT,D} against a reference A-B-BIN captured at acceptance.
// TESTING
//  1. A=0x0000_0005, B=0x0000_0003, BIN=0 -> D=0x0000_0002, BOUT=0, Z=0, V=0; out_valid at cycle 4 after accept.
//  2. A=0, B=1, BIN=0 -> D=0xFFFF_FFFF, BOUT=1, Z=0, V=0 (borrow ripples through all 4 chunks).
//  3. A=0x8000_0000, B=1, BIN=0 -> D=0x7FFF_FFFF, V=1, BOUT=0; then A=B=0x1234_5678, BIN=0 -> D=0, Z=1.
//  4. A=0x0000_0100, B=0x0000_0000, BIN=1 -> D=0x0000_00FF, BOUT=0 (inter-chunk borrow from BIN).
//  5. Hold out_ready=0 for 5 cycles in DONE -> out_valid and D stable, in_ready=0, a new in_valid is ignored;
//     then raise out_ready -> IDLE next cycle.
//  6. Drive rst_n=0 for one cycle mid-BUSY (cnt=2) -> next cycle: IDLE, in_ready=1, out_valid=0, D=0;
//     a new op then completes correctly.

Source files
------------

// File: rtl/adders_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : adders_pkg
// Brief  : Shared types and defaults for the adders library: the
//          serial_sub32 FSM state type and the default operand/chunk widths.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package adders_pkg;

  // Default operand width and per-cycle chunk width.
  localparam int SUB_WIDTH = 32;
  localparam int SUB_CHUNK = 8;

  // serial_sub32 control states; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    SUB_IDLE = 2'd0,
    SUB_BUSY = 2'd1,
    SUB_DONE = 2'd2
  } sub_state_t;

endpackage : adders_pkg
`default_nettype wire

// File: rtl/serial_sub32_props.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : serial_sub32_props
// Brief  : Bind-able checker for serial_sub32. Captures the full-width
//          reference A - B - BIN at acceptance and asserts that {BOUT, D}
//          matches it whenever a result is presented.
// Ports  : clk, rst_n, in_valid, in_ready, A, B, BIN  (observed inputs)
//          out_valid, D, BOUT                          (observed outputs)
// Rev    : 1.0  initial release
// ============================================================================
module serial_sub32_props
  import adders_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input logic             clk,
  input logic             rst_n,
  input logic             in_valid,
  input logic             in_ready,
  input logic [WIDTH-1:0] A,
  input logic [WIDTH-1:0] B,
  input logic             BIN,
  input logic             out_valid,
  input logic [WIDTH-1:0] D,
  input logic             BOUT
);

  // Bit WIDTH of the extended difference is the unsigned borrow out.
  logic [WIDTH:0] ref_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q <= '0;
    end else if (in_valid && in_ready) begin
      ref_q <= {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, BIN};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && out_valid) begin
      assert ({BOUT, D} == ref_q);
    end
  end

endmodule : serial_sub32_props
`default_nettype wire

// File: rtl/serial_sub32_sub_chunk.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : sub_chunk
// Brief  : Combinational CHUNK-bit subtract with borrow: d = a - b - bin.
// Ports  : a, b  [CHUNK-1:0]  minuend / subtrahend slice
//          bin                borrow in
//          d     [CHUNK-1:0]  difference slice
//          bout               borrow out (1 when a < b + bin)
// Rev    : 1.0  initial release
// ============================================================================
module sub_chunk
  import adders_pkg::*;
#(
  parameter int CHUNK = SUB_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  // One extra bit catches the wrap: a negative result sets bit CHUNK.
  logic [CHUNK:0] diff;

  assign diff = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bin};
  assign d    = diff[CHUNK-1:0];
  assign bout = diff[CHUNK];

endmodule : sub_chunk
`default_nettype wire

// File: rtl/serial_sub32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : serial_sub32
// Brief  : Multi-cycle chunked subtractor, D = A - B - BIN, CHUNK bits per
//          cycle starting at the LSB chunk. Valid/ready on input and output;
//          returns borrow, zero and signed-overflow flags.
// Ports  : clk, rst_n              clock, synchronous active-low reset
//          in_valid / in_ready     operand handshake (in_ready registered)
//          A, B [WIDTH-1:0], BIN   minuend, subtrahend, borrow in
//          out_valid / out_ready   result handshake (result held until taken)
//          D [WIDTH-1:0]           difference mod 2^WIDTH
//          BOUT, Z, V              borrow out, D==0, signed overflow
// Rev    : 1.0  initial release
// ============================================================================
module serial_sub32
  import adders_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,  // must be a multiple of CHUNK
  parameter int CHUNK = SUB_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BIN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             BOUT,
  output logic             Z,
  output logic             V
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  sub_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              borrow;
  logic [WIDTH-1:0]  d_reg;
  logic              bout_reg;
  logic              z_reg;
  logic              v_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;

  // Single chunk slice, steered by cnt so one subtractor serves all chunks.
  logic [CHUNK-1:0]  chunk_a;
  logic [CHUNK-1:0]  chunk_b;
  logic [CHUNK-1:0]  chunk_d;
  logic              chunk_bout;
  logic [WIDTH-1:0]  d_next;

  assign chunk_a = a_reg[32'(cnt) * CHUNK +: CHUNK];
  assign chunk_b = b_reg[32'(cnt) * CHUNK +: CHUNK];

  sub_chunk #(
    .CHUNK (CHUNK)
  ) u_sub_chunk (
    .a    (chunk_a),
    .b    (chunk_b),
    .bin  (borrow),
    .d    (chunk_d),
    .bout (chunk_bout)
  );

  // Difference with the current chunk merged in; on the last chunk this is
  // the complete result, so the flags can be computed in the same cycle.
  always_comb begin
    d_next = d_reg;
    d_next[32'(cnt) * CHUNK +: CHUNK] = chunk_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= SUB_IDLE;
      cnt           <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      borrow        <= 1'b0;
      d_reg         <= '0;
      bout_reg      <= 1'b0;
      z_reg         <= 1'b0;
      v_reg         <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        SUB_IDLE: begin
          if (in_valid) begin
            a_reg        <= A;
            b_reg        <= B;
            borrow       <= BIN;
            cnt          <= '0;
            in_ready_reg <= 1'b0;
            state        <= SUB_BUSY;
          end
        end

        SUB_BUSY: begin
          d_reg  <= d_next;
          borrow <= chunk_bout;
          if (cnt == LAST_CNT) begin
            bout_reg      <= chunk_bout;
            z_reg         <= ~|d_next;
            // Overflow only possible when operand signs differ.
            v_reg         <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                             (d_next[WIDTH-1] != a_reg[WIDTH-1]);
            out_valid_reg <= 1'b1;
            cnt           <= '0;
            state         <= SUB_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SUB_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= SUB_IDLE;
          end
        end

        default: begin
          state         <= SUB_IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign D         = d_reg;
  assign BOUT      = bout_reg;
  assign Z         = z_reg;
  assign V         = v_reg;

endmodule : serial_sub32
`default_nettype wire

// File: tb/tb_serial_sub32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_serial_sub32
// Brief  : Self-checking bench for serial_sub32. A transaction-level model
//          predicts handshake state and results every cycle; directed
//          vectors add hand-computed literal expectations.
// Rev    : 1.0  initial release
// ============================================================================
module tb_serial_sub32;
  import adders_pkg::*;

  localparam int W   = SUB_WIDTH;
  localparam int NCH = SUB_WIDTH / SUB_CHUNK;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         BIN       = 1'b0;
  logic [W-1:0] A         = '0;
  logic [W-1:0] B         = '0;
  logic         in_ready;
  logic         out_valid;
  logic         BOUT;
  logic         Z;
  logic         V;
  logic [W-1:0] D;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_sub32 #(.WIDTH(W), .CHUNK(SUB_CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .BIN       (BIN),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .BOUT      (BOUT),
    .Z         (Z),
    .V         (V)
  );

  serial_sub32_props #(.WIDTH(W)) u_props (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .BIN       (BIN),
    .out_valid (out_valid),
    .D         (D),
    .BOUT      (BOUT)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference result from plain integer arithmetic: {V, Z, BOUT, D}.
  function automatic logic [W+2:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
    logic [W:0] full;
    longint     sd;
    longint     smax;
    longint     smin;
    logic       v;
    full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    sd   = longint'($signed(a)) - longint'($signed(b)) - longint'({63'd0, bin});
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    v    = (sd > smax) || (sd < smin);
    return {v, (full[W-1:0] == '0), full[W], full[W-1:0]};
  endfunction

  // Transaction model: accept -> NCH cycles of work -> result held until taken.
  logic         m_ready = 1'b1;
  logic         m_valid = 1'b0;
  int           m_left  = 0;
  logic [W-1:0] m_d     = '0;
  logic         m_b     = 1'b0;
  logic         m_z     = 1'b0;
  logic         m_v     = 1'b0;
  bit           m_live  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_live  <= 1'b1;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_valid <= 1'b1;
    end else if (m_ready && in_valid) begin
      {m_v, m_z, m_b, m_d} <= ref_sub(A, B, BIN);
      m_left  <= NCH;
      m_ready <= 1'b0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check("model_in_ready", 64'(in_ready), 64'(m_ready));
      check("model_out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        check("model_D", 64'(D), 64'(m_d));
        check("model_BOUT", 64'(BOUT), 64'(m_b));
        check("model_Z", 64'(Z), 64'(m_z));
        check("model_V", 64'(V), 64'(m_v));
      end
    end
  end

  // mode 0: take result one cycle after it appears; mode 1: stall 5 cycles in
  // DONE with a competing in_valid; mode 2: out_ready already high on entry.
  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bin, input logic [W-1:0] ed, input logic eb,
                       input logic ez, input logic ev, input int mode);
    int lat;
    if (mode == 2) out_ready = 1'b1;
    A = a; B = b; BIN = bin; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs after acceptance; the latched operands must not move.
    in_valid = 1'b0; A = ~a; B = ~b; BIN = ~bin;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, 64'(lat), 64'(NCH));
    check({nm, "_D"}, 64'(D), 64'(ed));
    check({nm, "_BOUT"}, 64'(BOUT), 64'(eb));
    check({nm, "_Z"}, 64'(Z), 64'(ez));
    check({nm, "_V"}, 64'(V), 64'(ev));
    if (mode == 1) begin
      for (int i = 0; i < 5; i++) begin
        A = 32'h5555_5555; B = 32'h1111_1111; in_valid = 1'b1;
        @(negedge clk);
        check({nm, "_hold_valid"}, 64'(out_valid), 64'd1);
        check({nm, "_hold_D"}, 64'(D), 64'(ed));
        check({nm, "_hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
    end
    if (mode != 2) out_ready = 1'b1;
    @(negedge clk);
    check({nm, "_out_valid_drop"}, 64'(out_valid), 64'd0);
    check({nm, "_in_ready_back"}, 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_D", 64'(D), 64'd0);
    check("rst_flags", 64'({BOUT, Z, V}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("t1_5m3",     32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 0);
    do_op("t2_0m1",     32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
    do_op("t3_ovf",     32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 0);
    do_op("t3_zero",    32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 0);
    do_op("t4_bin",     32'h0000_0100, 32'h0000_0000, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 0);
    do_op("t5_hold",    32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 32'hD2FF_CEE1, 1'b0, 1'b0, 1'b0, 1);
    do_op("t_early_rdy",32'h0000_0001, 32'h0000_0002, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 2);
    do_op("t_ovf_neg",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 0);

    // Reset in the middle of BUSY (third chunk pending).
    A = 32'hCAFE_F00D; B = 32'h1234_4321; BIN = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_in_ready", 64'(in_ready), 64'd1);
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_D", 64'(D), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("t6_after",   32'h0000_0010, 32'h0000_0020, 1'b0, 32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_sub32
`default_nettype wire
